// File: rtl/rtlola_pkg.sv
// Shared definitions for the periodic-enable monitor input path.
//   DATA_W / TIME_W    : default widths of sample value and timestamp
//   STAGE_W            : width of the LLC stage counter (4-cycle frame)
//   HLC_RELEASE_STAGE  : LLC stage in which queued events reach the HLC
//   event_t            : one queued event {value, timestamp}
package rtlola_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned TIME_W  = 64;
    localparam int unsigned STAGE_W = 2;

    localparam logic [STAGE_W-1:0] HLC_RELEASE_STAGE = '0;

    typedef struct packed {
        logic signed [DATA_W-1:0] value;
        logic        [TIME_W-1:0] timestamp;
    } event_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding timestamped events until their release frame.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push      : write wr_data; ignored when full unless pop is also accepted
//   pop       : advance the head; ignored when empty
//   wr_data   : entry to enqueue
//   rd_data   : current head entry (valid while !empty)
//   full/empty/level : occupancy status
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Read-first: when full, a same-edge pop frees the head slot, so the
    // push may land in it while the head is still read out this cycle.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL_CNT) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign level   = count;

endmodule

// File: rtl/input_event_stager.sv
// Input stage of the periodic-enable monitor: timestamps each new_input
// event, queues it, and releases at most one event per 4-cycle LLC frame
// on the edge entering the HLC release stage.
//   clk, rst     : LLC clock, synchronous active-high reset
//   en           : global enable; freezes counters, capture and release
//   input_a      : signed sample value
//   new_input    : event strobe, one event per high cycle
//   ev_data/ev_time/ev_valid : last released event, valid pulse in stage 0
//   stage        : LLC stage 0..3
//   hlc_tick     : en && stage == release stage
//   time_now     : free-running cycle counter
//   fifo_level   : queue occupancy
//   overflow     : sticky, set by the first dropped event
//   drop_cnt     : saturating count of dropped events
module input_event_stager #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TIME_W = 64,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic signed [DATA_W-1:0]           input_a,
    input  logic                               new_input,
    output logic signed [DATA_W-1:0]           ev_data,
    output logic        [TIME_W-1:0]           ev_time,
    output logic                               ev_valid,
    output logic        [rtlola_pkg::STAGE_W-1:0] stage,
    output logic                               hlc_tick,
    output logic        [TIME_W-1:0]           time_now,
    output logic        [$clog2(DEPTH):0]      fifo_level,
    output logic                               overflow,
    output logic        [DROP_W-1:0]           drop_cnt
);

    localparam int unsigned FW = DATA_W + TIME_W;
    localparam logic [rtlola_pkg::STAGE_W-1:0] RELEASE_STAGE =
        rtlola_pkg::HLC_RELEASE_STAGE;
    // Stage preceding the release stage; its closing edge is the pop edge.
    localparam logic [rtlola_pkg::STAGE_W-1:0] LAST_STAGE = RELEASE_STAGE - 1'b1;

    logic        [rtlola_pkg::STAGE_W-1:0] stage_q;
    logic        [TIME_W-1:0]              time_q;
    logic signed [DATA_W-1:0]              ev_data_q;
    logic        [TIME_W-1:0]              ev_time_q;
    logic                                  ev_valid_q;
    logic                                  overflow_q;
    logic        [DROP_W-1:0]              drop_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_wr;
    logic [FW-1:0] fifo_rd;
    logic          dropped;

    always_comb begin
        fifo_pop  = en && (stage_q == LAST_STAGE) && !fifo_empty;
        fifo_push = en && new_input && (!fifo_full || fifo_pop);
        dropped   = en && new_input && fifo_full && !fifo_pop;
        fifo_wr   = {input_a, time_q};
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q    <= '0;
            time_q     <= '0;
            ev_data_q  <= '0;
            ev_time_q  <= '0;
            ev_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (en) begin
            stage_q    <= stage_q + 1'b1;
            time_q     <= time_q + 1'b1;
            ev_valid_q <= fifo_pop;
            if (fifo_pop) begin
                ev_data_q <= fifo_rd[FW-1:TIME_W];
                ev_time_q <= fifo_rd[TIME_W-1:0];
            end
            if (dropped) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + 1'b1;
                end
            end
        end
    end

    // Pulses are qualified by en/rst so they read 0 while frozen or in reset.
    assign hlc_tick = en && !rst && (stage_q == RELEASE_STAGE);
    assign ev_valid = en && !rst && ev_valid_q;
    assign stage    = stage_q;
    assign time_now = time_q;
    assign ev_data  = ev_data_q;
    assign ev_time  = ev_time_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

endmodule
